// File: rtl/onchip_ram_pipelined.sv
// Pipelined Avalon-MM on-chip RAM that zero-fills itself after reset.
// Define ONCHIP_RAM_PARITY_EN to add per-byte even parity and a parity_error output.
module onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    init_done
`ifdef ONCHIP_RAM_PARITY_EN
  ,
  output logic                    parity_error
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit LAT2  = (READ_LATENCY == 2);
  localparam bit CLEAR = (CLEAR_ON_RESET != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Control state
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                  waitrequest_q, waitrequest_d;

  // Storage
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef ONCHIP_RAM_PARITY_EN
  logic [NB-1:0]         par_mem [DEPTH];
  logic [NB-1:0]         mem_rpar_q;
`endif

  // Write port
  logic                  accept, wr_acc, rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  // Read pipeline: s0 holds the accepted request, s1 the RAM output, s2 the optional extra stage
  logic                  s0_vld_q, s0_vld_d;
  logic [ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
`ifdef ONCHIP_RAM_PARITY_EN
  logic                  s1_perr;
  logic                  s2_perr_q, s2_perr_d;
`endif

  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_data;

  // ---------------------------------------------------------------------------
  // Transfer acceptance; a simultaneous read+write is treated as a write only.
  // ---------------------------------------------------------------------------
  assign accept = chipselect & (read | write) & ~waitrequest_q & clken;
  assign wr_acc = accept & write;
  assign rd_acc = accept & read & ~write;

  // ---------------------------------------------------------------------------
  // INIT/RUN sequencing and the zero-fill sweep counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d       = state_q;
    sweep_cnt_d   = sweep_cnt_q;
    waitrequest_d = waitrequest_q;
    if (clken && state_q == ST_INIT) begin
      if (!CLEAR || sweep_cnt_q == '1) state_d = ST_RUN;
      if (CLEAR) sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
    end
    waitrequest_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state elements use non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      state_q       <= ST_INIT;
      sweep_cnt_q   <= '0;
      waitrequest_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      sweep_cnt_q   <= sweep_cnt_d;
      waitrequest_q <= waitrequest_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port mux: sweep has priority because no transfer is accepted in INIT
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = writedata;
    mem_be    = byteenable;
    if (state_q == ST_INIT && CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the RAM array has no reset; clearing it is the sweep's job, which keeps it inferable as block RAM.
  always_ff @(posedge clk) begin
    if (clken && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
          par_mem[mem_waddr][b]    <= ^mem_wdata[8*b +: 8];
`endif
        end
      end
    end
    if (clken && s0_vld_q) begin
      mem_rdata_q <= mem[s0_addr_q];
`ifdef ONCHIP_RAM_PARITY_EN
      mem_rpar_q  <= par_mem[s0_addr_q];
`endif
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  // Even parity: stored bit equals the XOR of its byte, so any single-bit flip mismatches.
  always_comb begin
    s1_perr = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if ((^mem_rdata_q[8*b +: 8]) != mem_rpar_q[b]) s1_perr = 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline; clken low freezes every stage, including the presented output
  // ---------------------------------------------------------------------------
  always_comb begin
    s0_vld_d  = s0_vld_q;
    s0_addr_d = s0_addr_q;
    s1_vld_d  = s1_vld_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
`ifdef ONCHIP_RAM_PARITY_EN
    s2_perr_d = s2_perr_q;
`endif
    if (clken) begin
      s0_vld_d  = rd_acc;
      s0_addr_d = address;
      s1_vld_d  = s0_vld_q;
      s2_vld_d  = s1_vld_q;
      s2_data_d = mem_rdata_q;
`ifdef ONCHIP_RAM_PARITY_EN
      s2_perr_d = s1_perr;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_vld_q  <= 1'b0;
      s0_addr_q <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
      s2_perr_q <= 1'b0;
`endif
    end else begin
      s0_vld_q  <= s0_vld_d;
      s0_addr_q <= s0_addr_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
`ifdef ONCHIP_RAM_PARITY_EN
      s2_perr_q <= s2_perr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; readdata is masked to zero whenever it is not valid
  // ---------------------------------------------------------------------------
  assign out_vld  = LAT2 ? s2_vld_q  : s1_vld_q;
  assign out_data = LAT2 ? s2_data_q : mem_rdata_q;

  assign readdatavalid = out_vld;
  assign readdata      = out_vld ? out_data : '0;
  assign waitrequest   = waitrequest_q;
  assign init_done     = ~waitrequest_q;

`ifdef ONCHIP_RAM_PARITY_EN
  assign parity_error  = out_vld & (LAT2 ? s2_perr_q : s1_perr);
`endif

endmodule
